// File: rtl/lcd8080_if.sv
// 8080-style parallel LCD bus (CSX/DCX/WRX/RDX/RESET) between a controller and a panel.
interface lcd8080_if #(parameter int PW = 18);
    logic [PW-1:0] lcd_d_i;
    logic [7:0]    lcd_d_o;
    logic          lcd_oe;
    logic          lcd_cs;
    logic          lcd_rs;
    logic          lcd_wr;
    logic          lcd_rd;
    logic          lcd_rst;

    modport master (output lcd_d_i, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst,
                    input  lcd_d_o, lcd_oe);
    modport slave  (input  lcd_d_i, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst,
                    output lcd_d_o, lcd_oe);
endinterface

// File: rtl/lcd8080_target.sv
// Panel-side responder for the 8080 LCD bus: oversampled strobes, DBI register set,
// pixel RAM with RAMWR/RAMRD and a registered debug read port.
module lcd8080_target #(
    parameter int          AW = 8,
    parameter int          PW = 18,
    parameter logic [23:0] ID = 24'h5A5A01
) (
    input  logic          clk,
    input  logic          rst,
    lcd8080_if.slave      bus,
    output logic [7:0]    madctl,
    output logic [7:0]    pwr_mode,
    output logic [7:0]    cmd,
    input  logic [AW-1:0] pix_adr,
    output logic [PW-1:0] pix_dat
);
    localparam int DEPTH = 2**AW;

    typedef enum logic [1:0] {IDLE, WRDATA, RDSETUP, RDDRIVE} state_t;
    state_t state;

    // [0] first sync stage, [1] second (level used for decisions), [2] edge reference
    logic [2:0]    cs_q, wr_q, rd_q;
    logic [1:0]    rs_q, rp_q;
    logic [PW-1:0] d_q0, d_q1;

    logic [AW-1:0] ptr;
    logic [2:0]    pidx, ridx;
    logic          rd_blk;
    logic [7:0]    d_o_r;
    logic          oe_r;
    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q <= 3'b111;
            wr_q <= 3'b111;
            rd_q <= 3'b111;
            rs_q <= 2'b00;
            rp_q <= 2'b11;
        end else begin
            cs_q <= {cs_q[1:0], bus.lcd_cs};
            wr_q <= {wr_q[1:0], bus.lcd_wr};
            rd_q <= {rd_q[1:0], bus.lcd_rd};
            rs_q <= {rs_q[0],   bus.lcd_rs};
            rp_q <= {rp_q[0],   bus.lcd_rst};
        end
    end

    always_ff @(posedge clk) begin
        d_q0 <= bus.lcd_d_i;
        d_q1 <= d_q0;
    end

    logic       sel, wr_rise, rd_fall, rd_rise, cs_rise, pin_rst;
    logic       wr_cmd, wr_dat, rd_go, hard_rst, pix_we;
    logic [7:0] cmd_in, rd_byte;

    always_comb begin
        sel      = ~cs_q[1];
        wr_rise  = wr_q[1] & ~wr_q[2];
        rd_fall  = ~rd_q[1] & rd_q[2];
        rd_rise  = rd_q[1] & ~rd_q[2];
        cs_rise  = cs_q[1] & ~cs_q[2];
        pin_rst  = ~rp_q[1];
        cmd_in   = d_q1[7:0];
        wr_cmd   = sel & wr_rise & ~rs_q[1];
        wr_dat   = sel & wr_rise & rs_q[1];
        // a read strobe is honoured only when WRX is high and no overlap is pending
        rd_go    = sel & rd_fall & wr_q[1] & ~rd_blk;
        hard_rst = rst | pin_rst | (wr_cmd && cmd_in == 8'h01);
        pix_we   = ~rst & ~pin_rst & wr_dat & (state == WRDATA) & (cmd == 8'h2C);
    end

    always_comb begin
        rd_byte = 8'h00;
        if (ridx != 3'd0) begin
            case (cmd)
                8'h0A: rd_byte = pwr_mode;
                8'h0B: rd_byte = madctl;
                8'h04: begin
                    case (ridx)
                        3'd1:    rd_byte = ID[23:16];
                        3'd2:    rd_byte = ID[15:8];
                        3'd3:    rd_byte = ID[7:0];
                        default: rd_byte = 8'h00;
                    endcase
                end
                8'h2E:   rd_byte = mem[ptr][7:0];
                default: rd_byte = 8'h00;
            endcase
        end
    end

    // WRX and RDX low together: suppress reads until both strobes are back high
    always_ff @(posedge clk) begin
        if (rst)
            rd_blk <= 1'b0;
        else if (~wr_q[1] & ~rd_q[1])
            rd_blk <= 1'b1;
        else if (wr_q[1] & rd_q[1])
            rd_blk <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (hard_rst) begin
            state    <= IDLE;
            cmd      <= 8'h00;
            madctl   <= 8'h00;
            pwr_mode <= 8'h08;
            pidx     <= 3'd0;
            ridx     <= 3'd0;
            ptr      <= '0;
            oe_r     <= 1'b0;
            d_o_r    <= 8'h00;
        end else if (wr_cmd) begin
            cmd   <= cmd_in;
            pidx  <= 3'd0;
            ridx  <= 3'd0;
            oe_r  <= 1'b0;
            state <= WRDATA;
            case (cmd_in)
                8'h10:        pwr_mode[4] <= 1'b0;
                8'h11:        pwr_mode[4] <= 1'b1;
                8'h28:        pwr_mode[2] <= 1'b0;
                8'h29:        pwr_mode[2] <= 1'b1;
                8'h2C, 8'h2E: ptr <= '0;
                default: ;
            endcase
        end else if (cs_rise) begin
            state <= IDLE;
            pidx  <= 3'd0;
            oe_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rd_go) state <= RDSETUP;
                WRDATA: begin
                    if (wr_dat) begin
                        if (cmd == 8'h36 && pidx == 3'd0) madctl <= d_q1[7:0];
                        if (cmd == 8'h2C) ptr <= ptr + 1'b1;
                        if (pidx != 3'd7) pidx <= pidx + 3'd1;
                    end else if (rd_go) begin
                        state <= RDSETUP;
                    end
                end
                RDSETUP: begin
                    d_o_r <= rd_byte;
                    oe_r  <= 1'b1;
                    state <= RDDRIVE;
                end
                RDDRIVE: begin
                    if (rd_rise) begin
                        oe_r  <= 1'b0;
                        state <= WRDATA;
                        if (ridx != 3'd7) ridx <= ridx + 3'd1;
                        if (cmd == 8'h2E) ptr <= ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pix_we) mem[ptr] <= d_q1;
        pix_dat <= mem[pix_adr];
    end

    assign bus.lcd_d_o = d_o_r;
    assign bus.lcd_oe  = oe_r;
endmodule

// File: tb/tb_lcd8080_target.sv
// Randomised bench for lcd8080_target: controller-side bus driver, queue scoreboard
// for read bytes, and a command-level panel model.
`timescale 1ns/1ps
module tb_lcd8080_target;
    localparam int AW = 8;
    localparam int PW = 18;
    localparam int DEPTH = 2**AW;
    localparam logic [23:0] ID = 24'h5A5A01;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    madctl, pwr_mode, cmd;
    logic [AW-1:0] pix_adr;
    logic [PW-1:0] pix_dat;

    lcd8080_if #(.PW(PW)) bus ();

    lcd8080_target #(.AW(AW), .PW(PW), .ID(ID)) dut (
        .clk(clk), .rst(rst), .bus(bus), .madctl(madctl), .pwr_mode(pwr_mode),
        .cmd(cmd), .pix_adr(pix_adr), .pix_dat(pix_dat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // panel model
    logic [7:0]    m_cmd, m_madctl, m_pwr;
    int            m_pidx, m_ridx, m_ptr;
    bit            m_wr;
    logic [PW-1:0] m_ram [DEPTH];
    logic [7:0]    exp_q [$];
    logic [7:0]    last_rd;
    bit            oe_prev = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cmd = 8'h00; m_madctl = 8'h00; m_pwr = 8'h08;
        m_pidx = 0; m_ridx = 0; m_ptr = 0; m_wr = 1'b0;
    endtask

    task automatic wr_cycle(bit rs_v, logic [PW-1:0] d);
        bus.lcd_rs  = rs_v;
        bus.lcd_d_i = d;
        bus.lcd_wr  = 1'b0;
        step(4);
        bus.lcd_wr  = 1'b1;
        step(4);
    endtask

    task automatic do_cmd(logic [7:0] c);
        wr_cycle(1'b0, {{(PW-8){1'b0}}, c});
        if (c == 8'h01) begin
            model_reset();
        end else begin
            m_cmd = c; m_pidx = 0; m_ridx = 0; m_wr = 1'b1;
            case (c)
                8'h10: m_pwr[4] = 1'b0;
                8'h11: m_pwr[4] = 1'b1;
                8'h28: m_pwr[2] = 1'b0;
                8'h29: m_pwr[2] = 1'b1;
                8'h2C, 8'h2E: m_ptr = 0;
                default: ;
            endcase
        end
    endtask

    task automatic do_dat(logic [PW-1:0] d);
        wr_cycle(1'b1, d);
        if (m_wr) begin
            if (m_cmd == 8'h36 && m_pidx == 0) m_madctl = d[7:0];
            if (m_cmd == 8'h2C) begin
                m_ram[m_ptr] = d;
                m_ptr = (m_ptr + 1) % DEPTH;
            end
            if (m_pidx < 7) m_pidx++;
        end
    endtask

    task automatic do_read();
        logic [7:0] e;
        e = 8'h00;
        if (m_ridx >= 1) begin
            case (m_cmd)
                8'h0A: e = m_pwr;
                8'h0B: e = m_madctl;
                8'h04: begin
                    if (m_ridx == 1)      e = ID[23:16];
                    else if (m_ridx == 2) e = ID[15:8];
                    else if (m_ridx == 3) e = ID[7:0];
                end
                8'h2E: e = m_ram[m_ptr][7:0];
                default: ;
            endcase
        end
        exp_q.push_back(e);
        m_ridx++;
        if (m_cmd == 8'h2E) m_ptr = (m_ptr + 1) % DEPTH;
        m_wr = 1'b1;
        bus.lcd_rd = 1'b0;
        step(6);
        chk("oe_during_rd", bus.lcd_oe, 1'b1);
        bus.lcd_rd = 1'b1;
        step(5);
        chk("oe_after_rd", bus.lcd_oe, 1'b0);
        chk("dout_hold", bus.lcd_d_o, e);
    endtask

    task automatic cs_pulse();
        bus.lcd_cs = 1'b1;
        step(4);
        bus.lcd_cs = 1'b0;
        step(4);
        m_wr = 1'b0;
        m_pidx = 0;
    endtask

    task automatic pix_chk(int a);
        pix_adr = AW'(a);
        step(2);
        chk("pix_dat", pix_dat, m_ram[a]);
    endtask

    task automatic reg_chk();
        chk("madctl", madctl, m_madctl);
        chk("pwr_mode", pwr_mode, m_pwr);
        chk("cmd", cmd, m_cmd);
    endtask

    // monitor: every driven read byte must match the oldest expected byte
    initial begin
        forever begin
            @(negedge clk);
            if (bus.lcd_oe && !oe_prev) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: got %0h expected none", bus.lcd_d_o);
                end else begin
                    last_rd = exp_q.pop_front();
                    chk("rd_byte", bus.lcd_d_o, last_rd);
                end
            end
            oe_prev = bus.lcd_oe;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] cmds [12] = '{8'h11, 8'h10, 8'h29, 8'h28, 8'h36, 8'h2C,
                              8'h2E, 8'h0A, 8'h0B, 8'h04, 8'h01, 8'h00};

    initial begin
        logic [PW-1:0] d;
        int op;
        rst = 1'b1;
        bus.lcd_cs = 1'b1; bus.lcd_wr = 1'b1; bus.lcd_rd = 1'b1;
        bus.lcd_rs = 1'b0; bus.lcd_rst = 1'b1; bus.lcd_d_i = '0;
        pix_adr = '0;
        model_reset();
        step(2);
        rst = 1'b0;
        step(2);
        chk("rst_pwr_mode", pwr_mode, 8'h08);
        chk("rst_madctl", madctl, 8'h00);
        chk("rst_cmd", cmd, 8'h00);
        chk("rst_oe", bus.lcd_oe, 1'b0);
        chk("rst_dout", bus.lcd_d_o, 8'h00);
        bus.lcd_cs = 1'b0;
        step(4);

        // MADCTL: only the first parameter lands
        do_cmd(8'h36); do_dat(18'h55);
        chk("madctl_p0", madctl, 8'h55);
        chk("cmd_36", cmd, 8'h36);
        do_dat(18'hAA);
        chk("madctl_p1", madctl, 8'h55);

        // power mode read-back: dummy then 0x1C
        do_cmd(8'h11); do_cmd(8'h29); do_cmd(8'h0A);
        do_read(); do_read();
        chk("pwr_1c", pwr_mode, 8'h1C);

        do_cmd(8'h2C); do_dat(18'o767574); do_dat(18'o000001);
        pix_chk(0); pix_chk(1);

        // DEPTH+1 writes wrap onto word 0
        do_cmd(8'h2C);
        for (int i = 0; i <= DEPTH; i++) do_dat(PW'($urandom));
        pix_chk(0); pix_chk(1); pix_chk(DEPTH-1);
        do_cmd(8'h2E);
        do_read(); do_read(); do_read();

        do_cmd(8'h04);
        for (int i = 0; i < 5; i++) do_read();

        // overlapping WRX/RDX: the command is taken, the read is dropped
        bus.lcd_rs = 1'b0; bus.lcd_d_i = 18'h0B;
        bus.lcd_wr = 1'b0; step(4);
        bus.lcd_rd = 1'b0; step(4);
        bus.lcd_rd = 1'b1; step(4);
        bus.lcd_wr = 1'b1; step(4);
        m_cmd = 8'h0B; m_pidx = 0; m_ridx = 0; m_wr = 1'b1;
        chk("buserr_cmd", cmd, 8'h0B);
        do_read(); do_read();

        // RESET pin: clears registers and swallows a strobe inside the window
        do_cmd(8'h36); do_dat(18'h55);
        chk("madctl_pre_rst", madctl, 8'h55);
        bus.lcd_rst = 1'b0;
        step(1);
        bus.lcd_rs = 1'b0; bus.lcd_d_i = 18'h29; bus.lcd_wr = 1'b0;
        step(2);
        bus.lcd_wr = 1'b1;
        step(2);
        bus.lcd_rst = 1'b1;
        step(6);
        model_reset();
        reg_chk();
        chk("pin_rst_oe", bus.lcd_oe, 1'b0);

        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                if ($urandom_range(0, 5) == 0) do_cmd(8'($urandom));
                else do_cmd(cmds[$urandom_range(0, 11)]);
            end else if (op <= 5) begin
                d = PW'($urandom);
                do_dat(d);
            end else if (op <= 7) begin
                do_read();
            end else if (op == 8) begin
                pix_chk($urandom_range(0, DEPTH-1));
            end else begin
                cs_pulse();
            end
            reg_chk();
        end

        step(4);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
